// File: rtl/magnitude_bcd_converter.sv
// ---------------------------------------------------------------------------
// magnitude_bcd_converter
//
// Converts an unsigned binary magnitude into packed BCD digits. It uses the
// shift-add-3 (double-dabble) algorithm and processes one input bit per clock.
// The last result is held on out_bcd until the next conversion completes,
// so the output can drive a display directly.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid this cycle
//   in_ready   a new value can be accepted (IDLE only)
//   in_data    unsigned binary magnitude, WIDTH bits
//   out_valid  out_bcd holds a fresh result that has not been consumed yet
//   out_ready  the consumer accepts the result
//   out_bcd    packed BCD, units digit in [3:0], 4*DIGITS bits
//   busy       a conversion is shifting
// ---------------------------------------------------------------------------
module magnitude_bcd_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter int CNT_W  = $clog2(WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  busy
);

   // True when DIGITS decimal digits can represent 2^w - 1.
   function automatic bit digits_fit(input int w, input int d);
      longint unsigned lim;
      longint unsigned max_val;
      if (w >= 63) return 1'b0;
      max_val = (64'd1 << w) - 64'd1;
      lim = 64'd1;
      for (int i = 0; i < d; i++) begin
         if (lim > max_val) return 1'b1;
         lim = lim * 64'd10;
      end
      return lim > max_val;
   endfunction

   generate
      if (WIDTH < 1) begin : g_bad_width
         $error("magnitude_bcd_converter: WIDTH must be >= 1");
      end
      if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_digits
         $error("magnitude_bcd_converter: DIGITS too small for WIDTH");
      end
      if (CNT_W != $clog2(WIDTH + 1)) begin : g_bad_cnt
         $error("magnitude_bcd_converter: CNT_W is derived and must not be overridden");
      end
   endgenerate

   localparam int BCD_W = 4 * DIGITS;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              state_reg;
   logic [WIDTH-1:0]    bin_reg;
   logic [BCD_W-1:0]    bcd_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [BCD_W-1:0]    out_bcd_reg;
   logic                out_valid_reg;

   logic [BCD_W-1:0]    bcd_adj;
   logic [BCD_W-1:0]    bcd_next;

   // Add-3 correction on every digit in parallel. The digits come from the
   // pre-shift working value. A digit is never above 9 here, so a 4-bit add
   // cannot overflow into the next digit.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] digit;
         assign digit = bcd_reg[4*gi +: 4];
         assign bcd_adj[4*gi +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
      end
   endgenerate

   // Shift the corrected digits left, pulling in the next binary MSB.
   assign bcd_next = {bcd_adj[BCD_W-2:0], bin_reg[WIDTH-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         bin_reg       <= '0;
         bcd_reg       <= '0;
         cnt_reg       <= '0;
         out_bcd_reg   <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  bin_reg   <= in_data;
                  bcd_reg   <= '0;
                  cnt_reg   <= CNT_INIT;
                  state_reg <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               bcd_reg <= bcd_next;
               bin_reg <= bin_reg << 1;
               cnt_reg <= cnt_reg - CNT_ONE;
               // This is the last shift. Publish the result directly from the
               // shifted value. out_bcd is written only here.
               if (cnt_reg == CNT_ONE) begin
                  out_bcd_reg   <= bcd_next;
                  out_valid_reg <= 1'b1;
                  state_reg     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= S_IDLE;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // These outputs are decoded from the state register only. No input reaches
   // an output in the same cycle.
   assign in_ready  = (state_reg == S_IDLE);
   assign busy      = (state_reg == S_SHIFT);
   assign out_valid = out_valid_reg;
   assign out_bcd   = out_bcd_reg;

endmodule

// File: tb/tb_magnitude_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_magnitude_bcd_converter
//
// Self-checking bench for magnitude_bcd_converter. It instantiates an 8-bit
// and 3-digit DUT and a 16-bit and 5-digit DUT.
// ---------------------------------------------------------------------------
module tb_magnitude_bcd_converter;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_bcd;
   logic        busy;

   logic        in_valid16;
   logic        in_ready16;
   logic [15:0] in_data16;
   logic        out_valid16;
   logic        out_ready16;
   logic [19:0] out_bcd16;
   logic        busy16;

   int checks   = 0;
   int failures = 0;

   logic [11:0] sb_q[$];

   typedef struct {
      logic [7:0]  din;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[260];

   magnitude_bcd_converter #(.WIDTH(8), .DIGITS(3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .busy      (busy)
   );

   magnitude_bcd_converter #(.WIDTH(16), .DIGITS(5)) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .in_data   (in_data16),
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .out_bcd   (out_bcd16),
      .busy      (busy16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: decimal digits by repeated division.
   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int          x;
      r = '0;
      x = v;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present v and wait until it has been accepted. The expected result goes
   // onto the scoreboard.
   task automatic send(input logic [7:0] v, input logic [11:0] exp);
      int n;
      in_valid = 1'b1;
      in_data  = v;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) check("send_in_ready_timeout", 32'(in_ready), 32'd1);
      sb_q.push_back(exp);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      if (sb_q.size() != 0) check(name, 32'(sb_q.size()), 32'd0);
   endtask

   // Scoreboard monitor. A handshake completes on the next posedge, so the
   // result is compared at the preceding negedge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_output", 32'(out_bcd), 32'hFFFF);
         end else begin
            logic [11:0] e;
            e = sb_q.pop_front();
            check("scoreboard_bcd", 32'(out_bcd), 32'(e));
            $display("txn out_bcd=%03h expected=%03h", out_bcd, e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] v16;
      logic [15:0] tv[2];

      // Full sweep from the model, plus literal anchors.
      for (int i = 0; i < 256; i++) begin
         vecs[i].din = 8'(i);
         vecs[i].exp = to_bcd(i)[11:0];
      end
      vecs[256] = '{8'd255, 12'h255};
      vecs[257] = '{8'd99,  12'h099};
      vecs[258] = '{8'd10,  12'h010};
      vecs[259] = '{8'd128, 12'h128};

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
      in_valid16  = 1'b0;
      in_data16   = '0;
      out_ready16 = 1'b0;

      #12;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_bcd",   32'(out_bcd),   32'd0);
      check("reset_busy",      32'(busy),      32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_reset_in_ready", 32'(in_ready), 32'd1);

      // Latency: out_valid must rise exactly 8 edges after acceptance.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'd0;
      sb_q.push_back(12'h000);
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check($sformatf("latency_out_valid_%0d", i), 32'(out_valid), 32'(i == 8));
         if (i < 8) check($sformatf("latency_busy_%0d", i), 32'(busy), 32'd1);
      end
      check("latency_out_bcd", 32'(out_bcd), 32'h000);
      tick();
      check("consume_out_valid", 32'(out_valid), 32'd0);
      check("consume_in_ready",  32'(in_ready),  32'd1);

      // Table-driven sweep.
      for (int i = 0; i < 260; i++) begin
         send(vecs[i].din, vecs[i].exp);
         wait_drain($sformatf("drain_vec_%0d", i));
      end

      // Backpressure.
      out_ready = 1'b0;
      send(8'd173, 12'h173);
      for (int n = 0; n < 20 && !out_valid; n++) tick();
      check("bp_out_valid_rise", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      in_data  = 8'd42;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (out_valid !== 1'b1 || out_bcd !== 12'h173 || in_ready !== 1'b0 || busy !== 1'b0)
            check($sformatf("bp_hold_%0d", n), {out_valid, in_ready, busy, 17'd0, out_bcd},
                  {1'b1, 1'b0, 1'b0, 17'd0, 12'h173});
      end
      check("bp_out_bcd_held", 32'(out_bcd), 32'h173);
      sb_q.push_back(12'h042);
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("bp_42_accepted_busy", 32'(busy), 32'd1);
      wait_drain("drain_bp");
      check("bp_out_bcd_42", 32'(out_bcd), 32'h042);

      // Back-to-back, with in_valid held high.
      in_valid = 1'b1;
      in_data  = 8'd7;
      sb_q.push_back(12'h007);
      tick();
      in_data = 8'd200;
      sb_q.push_back(12'h200);
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 8) check("b2b_first_done", 32'(out_bcd), 32'h007);
         if (i == 9) check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
      end
      check("b2b_second_accepted", 32'(busy), 32'd1);
      in_valid = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         if (j < 8 && out_bcd !== 12'h007) check($sformatf("b2b_hold_%0d", j), 32'(out_bcd), 32'h007);
      end
      check("b2b_second_bcd", 32'(out_bcd), 32'h200);
      wait_drain("drain_b2b");

      // 16-bit, 5-digit instance.
      tv[0] = 16'd65535;
      tv[1] = 16'd40961;
      for (int k = 0; k < 2; k++) begin
         v16 = tv[k];
         in_valid16 = 1'b1;
         in_data16  = v16;
         tick();
         in_valid16 = 1'b0;
         for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) check("w16_not_early", 32'(out_valid16), 32'd0);
         end
         check("w16_out_valid", 32'(out_valid16), 32'd1);
         check("w16_out_bcd", 32'(out_bcd16), 32'(to_bcd(int'(v16))));
         $display("txn w16 in=%0d out_bcd=%05h", v16, out_bcd16);
         out_ready16 = 1'b1;
         tick();
         out_ready16 = 1'b0;
         check("w16_consumed", 32'(out_valid16), 32'd0);
      end

      // Reset during the 4th shift cycle.
      in_valid = 1'b1;
      in_data  = 8'd255;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("mid_busy_before_reset", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_reset_out_valid", 32'(out_valid), 32'd0);
      check("mid_reset_out_bcd",   32'(out_bcd),   32'd0);
      check("mid_reset_busy",      32'(busy),      32'd0);
      sb_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_reset_in_ready", 32'(in_ready), 32'd1);
      send(8'd61, 12'h061);
      wait_drain("drain_61");
      check("after_reset_61", 32'(out_bcd), 32'h061);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
